sangdan_tatdan_2led: RTL and testbench

//  8-LED chaser: LEDs light up two at a time from bit 0 upward until all eight are lit.

---
 rtl/sangdan_tatdan_2led.sv | 131 +++++++++++++
 tb/tb_sangdan_tatdan_2led.sv | 116 +++++++++++
 2 files changed

// File: rtl/sangdan_tatdan_2led.sv
// sangdan_tatdan_2led: 8-LED two-at-a-time chaser.
// LEDs fill pairwise from bit 0 upward (00->03->0F->3F->FF), then drain pairwise
// from bit 0 upward (FF->FC->F0->C0->00), and the cycle repeats. A prescaler
// divides the board clock so the pattern steps once every TICK_DIV clocks.
//
// Optional feature, macro SANGDAN_HOLD_EN: when defined, the pattern dwells at
// FF and at 00 for HOLD_TICKS extra steps. When undefined, HOLD_TICKS is ignored
// and the hold states are unreachable.
//
// Reset rs is synchronous and active-high; it has priority over a step.

module sangdan_tatdan_2led #(
  parameter int unsigned TICK_DIV   = 1,  // clocks per pattern step, >= 1
  parameter int unsigned HOLD_TICKS = 2   // extra steps at FF and 00 (hold build only)
) (
  input  logic       clk,
  input  logic       rs,
  output logic [7:0] led
);

  // Effective hold length; forced to zero when the hold feature is not built in.
`ifdef SANGDAN_HOLD_EN
  localparam int unsigned HOLD_STEPS = HOLD_TICKS;
`else
  localparam int unsigned HOLD_STEPS = 0 * HOLD_TICKS;
`endif

  // Prescaler sizing: width max(1, clog2(TICK_DIV)), wraps at TICK_DIV-1.
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);

  // Hold counter sizing: counts 0 .. HOLD_STEPS-1.
  localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  // Pattern end points.
  localparam logic [7:0] LED_FULL  = 8'hFF;
  localparam logic [7:0] LED_EMPTY = 8'h00;

  // FSM state encoding.
  localparam logic [1:0] FILL       = 2'd0;
  localparam logic [1:0] DRAIN      = 2'd1;
  localparam logic [1:0] HOLD_FULL  = 2'd2;
  localparam logic [1:0] HOLD_EMPTY = 2'd3;

  logic [DW-1:0] div, div_nxt;
  logic          tick;
  logic [1:0]    state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [7:0]    led_nxt;
  logic [7:0]    fill_val;
  logic [7:0]    drain_val;
  logic          hold_done;

  // Prescaler: tick marks the last clock of each step period.
  always_comb begin
    tick    = (div == DIV_LAST);
    div_nxt = tick ? '0 : div + 1'b1;
  end

  // Candidate next patterns and hold-exit condition.
  always_comb begin
    fill_val  = {led[5:0], 2'b11};
    drain_val = {led[5:0], 2'b00};
    hold_done = (hcnt == HOLD_LAST);
  end

  // Next-state logic: the pattern and FSM move only on a prescaler tick.
  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    hcnt_nxt  = hcnt;
    if (tick) begin
      case (state)
        FILL: begin
          led_nxt = fill_val;
          if (fill_val == LED_FULL) begin
            hcnt_nxt  = '0;
            state_nxt = (HOLD_STEPS == 0) ? DRAIN : HOLD_FULL;
          end
        end
        DRAIN: begin
          led_nxt = drain_val;
          if (drain_val == LED_EMPTY) begin
            hcnt_nxt  = '0;
            state_nxt = (HOLD_STEPS == 0) ? FILL : HOLD_EMPTY;
          end
        end
        HOLD_FULL: begin
          // led stays FF; leave after HOLD_STEPS ticks.
          if (hold_done) begin
            hcnt_nxt  = '0;
            state_nxt = DRAIN;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        HOLD_EMPTY: begin
          // led stays 00; leave after HOLD_STEPS ticks.
          if (hold_done) begin
            hcnt_nxt  = '0;
            state_nxt = FILL;
          end else begin
            hcnt_nxt = hcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = FILL;
          led_nxt   = LED_EMPTY;
          hcnt_nxt  = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over a tick.
  always_ff @(posedge clk) begin
    if (rs) begin
      div   <= '0;
      state <= FILL;
      hcnt  <= '0;
      led   <= LED_EMPTY;
    end else begin
      div   <= div_nxt;
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      led   <= led_nxt;
    end
  end

endmodule

// File: tb/tb_sangdan_tatdan_2led.sv
// Directed bench for sangdan_tatdan_2led: one instance stepping every clock and
// one stepping every fourth clock. Expected values come from a hand-written table.

module tb_sangdan_tatdan_2led;

  logic       clk;
  logic       rs;
  logic [7:0] led1;
  logic [7:0] led4;

  int total;
  int bad;

`ifdef SANGDAN_HOLD_EN
  localparam int P = 12;
`else
  localparam int P = 8;
`endif
  logic [7:0] seq [P];

  sangdan_tatdan_2led #(.TICK_DIV(1), .HOLD_TICKS(2)) dut1 (
    .clk (clk),
    .rs  (rs),
    .led (led1)
  );

  sangdan_tatdan_2led #(.TICK_DIV(4), .HOLD_TICKS(2)) dut4 (
    .clk (clk),
    .rs  (rs),
    .led (led4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    logic       ok;
    logic       found;
    int         d;

    total = 0;
    bad   = 0;
`ifdef SANGDAN_HOLD_EN
    seq = '{8'h03, 8'h0F, 8'h3F, 8'hFF, 8'hFF, 8'hFF,
            8'hFC, 8'hF0, 8'hC0, 8'h00, 8'h00, 8'h00};
`else
    seq = '{8'h03, 8'h0F, 8'h3F, 8'hFF, 8'hFC, 8'hF0, 8'hC0, 8'h00};
`endif

    // Reset held for 10 edges: both outputs stay dark.
    rs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_hold_div1", led1, 8'h00);
      check("rst_hold_div4", led4, 8'h00);
    end
    rs = 1'b0;

    // Full sequence; the divide-by-4 instance first steps on the 4th edge.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("seq_div1", led1, seq[(k - 1) % P]);
      if (k < 4) check("seq_div4", led4, 8'h00);
      else       check("seq_div4", led4, seq[((k / 4) - 1) % P]);
    end

    // Long run: only legal values, each step changes exactly one LED pair.
    prev = led1;
    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      cur = led1;
      ok  = (cur == 8'h00) || (cur == 8'h03) || (cur == 8'h0F) || (cur == 8'h3F) ||
            (cur == 8'hFF) || (cur == 8'hFC) || (cur == 8'hF0) || (cur == 8'hC0);
      check("legal_value", {7'd0, ok}, 8'h01);
      d = $countones(prev ^ cur);
`ifdef SANGDAN_HOLD_EN
      ok = (d == 2) || (d == 0 && (cur == 8'hFF || cur == 8'h00));
`else
      ok = (d == 2);
`endif
      check("two_bit_step", {7'd0, ok}, 8'h01);
      prev = cur;
    end

    // One-edge reset while lit to 3F forces a restart in FILL.
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (led1 == 8'h3F) found = 1'b1;
    end
    check("find_3f", {7'd0, found}, 8'h01);
    rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    check("mid_rst_div1", led1, 8'h00);
    check("mid_rst_div4", led4, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("restart_fill", led1, seq[k - 1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
